hv_core_mt: RTL and testbench
=============================

HV_CORE_MT -- requirements
Module: hv_core_mt

Interface
REQ-001 Parameter DIM, default 1024, hypervector width in bits; legal values are 8 or more.
REQ-002 Parameter THREADS, default 10, hardware thread count; legal range is 2 to 16.
REQ-003 Parameter ITEM_AW, default 10, item-memory address width; depth is 2^ITEM_AW.
REQ-004 Parameter CNT_W, default 8, signed bundle-counter width; legal range is 2 to 16.
REQ-005 clk  in  1  sole clock; all logic is rising-edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 gen  in  1  request to write rand_num into the item memory at gen_addr.
REQ-008 gen_addr  in  ITEM_AW  item-memory address for a gen write.
REQ-009 gen_ready  out  1  a gen write is taken this cycle.
REQ-010 rand_num  in  DIM  random vector, used by gen writes and as the SIGN tie-break.
REQ-011 in_valid / in_ready  in / out  1 / 1  instruction handshake; an instruction is accepted when both are 1.
REQ-012 in_inst  in  16  instruction word; op=[15:12], imm=[ITEM_AW-1:0].
REQ-013 out_valid / out_ready  out / in  1 / 1  store-result handshake.
REQ-014 out_data  out  DIM  stored vector.
REQ-015 out_thread  out  $clog2(THREADS)  thread that issued the store.
REQ-016 last  out  1  one-cycle end-of-program pulse.

Function
REQ-017 The current thread index t starts at 0, increments on each accepted instruction, and wraps from THREADS-1 to 0.
REQ-018 Each thread has its own DIM-bit R1 and R2 registers and DIM signed CNT_W-bit counters.
REQ-019 The pipeline has two stages. Stage A captures the accepted instruction and t, and issues the synchronous item-memory read at address imm. Stage B executes one cycle after acceptance.
REQ-020 stall = out_valid & ~out_ready; in_ready = ~stall; while stall is 1, stage B holds and performs no state update.
REQ-021 Op 0 NOP: no effect.
REQ-022 Op 1 LOAD: R2[t] <= item[imm].
REQ-023 Op 2 MOVE: R1[t] <= R2[t].
REQ-024 Op 3 XOR: R2[t] <= R1[t] ^ R2[t].
REQ-025 Op 4 PERM: R2[t] is rotated left by k = imm mod DIM, so new bit (i+k) mod DIM = old bit i.
REQ-026 Op 5 ACC: for each bit i, cnt[t][i] += (R2[t][i] ? +1 : -1), saturating at +(2^(CNT_W-1)-1) and -(2^(CNT_W-1)).
REQ-027 Op 6 SIGN: for each bit i, R2[t][i] <= 1 if cnt>0, 0 if cnt<0, and rand_num[i] (sampled in stage B) if cnt==0; all cnt[t] are then cleared to 0.
REQ-028 Op 7 STORE: on the next cycle, out_valid=1, out_data=R2[t], out_thread=t; these are held stable until out_ready=1.
REQ-029 A STORE executing in the same cycle as an out_ready handshake drives the new data directly; no bubble is inserted.
REQ-030 Op 8 WB: item[imm] <= R2[t].
REQ-031 Op 15 LAST: last=1 for exactly one cycle, one cycle after stage B; it is never asserted while out_valid=1.
REQ-032 Ops 9-14 are reserved, execute as NOP, and still advance t.
REQ-033 A same-thread result is visible to that thread's next instruction. This is guaranteed because THREADS≥2 and instructions are issued round-robin.
REQ-034 A LOAD reads the item-memory contents that precede any WB executing in the same cycle (read-before-write).
REQ-035 gen_ready = ~(stage-B WB valid).
REQ-036 When gen & gen_ready, item[gen_addr] <= rand_num. A gen request colliding with a WB is not taken and must be held by the requester.
REQ-037 gen writes are permitted while instructions are flowing.
REQ-038 No combinational path exists from in_valid to in_ready, or from out_ready to out_data.

Reset
REQ-039 While rst=1: in_ready=0, gen_ready=0, out_valid=0, out_data=0, out_thread=0, last=0.
REQ-040 While rst=1, t and both pipeline stages are cleared and every counter is set to 0.
REQ-041 R1, R2 and the item memory are not reset; their contents are undefined until written.
REQ-042 A reset asserted mid-program discards in-flight instructions and any pending store.
REQ-043 Output values take effect the cycle after rst rises. in_ready=1 the cycle after rst falls.

Verification (DIM=8, THREADS=2, CNT_W=3)
REQ-044 gen item[3]=0xA5, then LOAD 3, NOP, STORE, NOP -> out_data=0xA5, out_thread=0.
REQ-045 Thread 0 R2=0x81, PERM 1 -> stored value is 0x03. Thread 0 R2=0x81, PERM 9 -> stored value is 0x03 (9 mod 8 = 1).
REQ-046 Thread 0 ACCs 0xFF five times, then SIGN with rand_num=0x00 -> R2=0xFF and counters saturate at +3. ACC 0x0F, ACC 0xF0, then SIGN with rand_num=0x5A -> R2=0x5A.
REQ-047 Hold out_ready=0 for 4 cycles after a STORE -> in_ready=0 and out_data stays stable. Release out_ready -> exactly one handshake occurs and issue resumes.
REQ-048 WB in stage B coincides with gen to the same address -> gen_ready=0, the WB value is written, and gen completes the next cycle.
REQ-049 Assert rst for 1 cycle while a STORE is pending -> out_valid=0, t=0, and a following SIGN with rand_num=0x3C yields 0x3C.

Source files
------------

// File: rtl/hv_core_mt.sv
// hv_core_mt: multithreaded hypervector core.
// Round-robin issue across THREADS hardware threads, each with private R1/R2
// hypervector registers and a bank of signed saturating bundle counters.
// Two-stage pipeline: stage A accepts an instruction and reads the item
// memory, stage B executes one cycle later.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   gen, gen_addr, gen_ready  write rand_num into item[gen_addr]
//   rand_num                  random vector (gen data, SIGN tie-break)
//   in_valid/in_ready/in_inst instruction handshake, op=[15:12], imm=[ITEM_AW-1:0]
//   out_valid/out_ready       store-result handshake
//   out_data, out_thread      stored vector and issuing thread
//   last                      one-cycle end-of-program pulse
module hv_core_mt #(
  parameter int DIM     = 1024,
  parameter int THREADS = 10,
  parameter int ITEM_AW = 10,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       gen,
  input  logic [ITEM_AW-1:0]         gen_addr,
  output logic                       gen_ready,
  input  logic [DIM-1:0]             rand_num,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [15:0]                in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DIM-1:0]             out_data,
  output logic [$clog2(THREADS)-1:0] out_thread,
  output logic                       last
);

  localparam int TW = $clog2(THREADS);

  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_MOVE  = 4'd2;
  localparam logic [3:0] OP_XOR   = 4'd3;
  localparam logic [3:0] OP_PERM  = 4'd4;
  localparam logic [3:0] OP_ACC   = 4'd5;
  localparam logic [3:0] OP_SIGN  = 4'd6;
  localparam logic [3:0] OP_STORE = 4'd7;
  localparam logic [3:0] OP_WB    = 4'd8;
  localparam logic [3:0] OP_LAST  = 4'd15;

  localparam logic signed [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic signed [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DIM-1:0]          item [2**ITEM_AW];
  logic [DIM-1:0]          r1   [THREADS];
  logic [DIM-1:0]          r2   [THREADS];
  logic signed [CNT_W-1:0] cnt  [THREADS][DIM];

  // run is low during reset and its first following cycle, which keeps the
  // handshake outputs registered with respect to rst.
  logic               run;
  logic [TW-1:0]      t;
  logic               a_valid;
  logic [3:0]         a_op;
  logic [ITEM_AW-1:0] a_imm;
  logic [TW-1:0]      a_thr;
  logic [DIM-1:0]     a_rd;

  logic           stall, accept, exec, wb_we, gen_we;
  logic [DIM-1:0] r1_cur, r2_cur, r2_rot, r2_sign;
  logic [31:0]    rot_k;

  assign stall     = out_valid & ~out_ready;
  assign in_ready  = run & ~stall;
  assign accept    = in_valid & in_ready;
  assign exec      = a_valid & ~stall & ~rst;
  assign wb_we     = exec & (a_op == OP_WB);
  assign gen_ready = run & ~(a_valid & (a_op == OP_WB));
  assign gen_we    = gen & gen_ready;

  assign r1_cur = r1[a_thr];
  assign r2_cur = r2[a_thr];

  // Shifting by DIM yields zero, so k == 0 degenerates to the identity.
  assign rot_k  = 32'(a_imm) % 32'(DIM);
  assign r2_rot = (r2_cur << rot_k) | (r2_cur >> (32'(DIM) - rot_k));

  always_comb begin
    r2_sign = '0;
    for (int i = 0; i < DIM; i++) begin
      if (cnt[a_thr][i] == '0) r2_sign[i] = rand_num[i];
      else                     r2_sign[i] = ~cnt[a_thr][i][CNT_W-1];
    end
  end

  // Read is issued at acceptance with non-blocking semantics, so a LOAD sees
  // the contents from before any write landing on the same edge.
  always_ff @(posedge clk) begin
    if (gen_we) item[gen_addr] <= rand_num;
    if (wb_we)  item[a_imm]    <= r2_cur;
    if (accept) a_rd           <= item[in_inst[ITEM_AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (exec) begin
      case (a_op)
        OP_LOAD: r2[a_thr] <= a_rd;
        OP_MOVE: r1[a_thr] <= r2_cur;
        OP_XOR:  r2[a_thr] <= r1_cur ^ r2_cur;
        OP_PERM: r2[a_thr] <= r2_rot;
        OP_SIGN: r2[a_thr] <= r2_sign;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int th = 0; th < THREADS; th++)
        for (int i = 0; i < DIM; i++) cnt[th][i] <= '0;
    end else if (exec && a_op == OP_ACC) begin
      for (int i = 0; i < DIM; i++) begin
        if (r2_cur[i]) begin
          if (cnt[a_thr][i] != CNT_MAX) cnt[a_thr][i] <= cnt[a_thr][i] + CNT_ONE;
        end else begin
          if (cnt[a_thr][i] != CNT_MIN) cnt[a_thr][i] <= cnt[a_thr][i] - CNT_ONE;
        end
      end
    end else if (exec && a_op == OP_SIGN) begin
      for (int i = 0; i < DIM; i++) cnt[a_thr][i] <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run        <= 1'b0;
      t          <= '0;
      a_valid    <= 1'b0;
      a_op       <= '0;
      a_imm      <= '0;
      a_thr      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_thread <= '0;
      last       <= 1'b0;
    end else begin
      run <= 1'b1;
      if (accept) t <= (t == TW'(THREADS - 1)) ? '0 : t + TW'(1);
      if (!stall) begin
        a_valid <= accept;
        if (accept) begin
          a_op  <= in_inst[15:12];
          a_imm <= in_inst[ITEM_AW-1:0];
          a_thr <= t;
        end
      end
      // LAST only executes when out_valid is clear or handshaking, so the
      // pulse can never overlap a pending store.
      last <= exec & (a_op == OP_LAST);
      if (exec && a_op == OP_STORE) begin
        out_valid  <= 1'b1;
        out_data   <= r2_cur;
        out_thread <= a_thr;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  generate
    if (ITEM_AW < 12) begin : g_unused
      logic unused_inst_bits;
      assign unused_inst_bits = ^in_inst[11:ITEM_AW];
    end
  endgenerate

endmodule

// File: tb/tb_hv_core_mt.sv
module tb_hv_core_mt;
  localparam int DIM = 8, THREADS = 2, ITEM_AW = 4, CNT_W = 3;
  localparam int CMAX = (1 << (CNT_W - 1)) - 1;
  localparam int CMIN = -(1 << (CNT_W - 1));

  logic clk = 1'b0;
  logic rst, gen, gen_ready, in_valid, in_ready, out_valid, out_ready, last;
  logic [ITEM_AW-1:0] gen_addr;
  logic [DIM-1:0] rand_num, out_data;
  logic [15:0] in_inst;
  logic [0:0] out_thread;

  always #5 clk = ~clk;

  hv_core_mt #(.DIM(DIM), .THREADS(THREADS), .ITEM_AW(ITEM_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .gen(gen), .gen_addr(gen_addr), .gen_ready(gen_ready),
    .rand_num(rand_num), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_thread(out_thread), .last(last)
  );

  int n_pass = 0, n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    else n_pass++;
  endtask

  // Behavioural model: architectural state plus the visible pipeline timing.
  logic [7:0] m_item [16];
  logic [7:0] m_r1 [THREADS];
  logic [7:0] m_r2 [THREADS];
  int         m_cnt [THREADS][DIM];
  bit         m_known = 0, m_run = 0, m_ov = 0, m_last = 0, m_bv = 0;
  logic [7:0] m_od = '0, m_brd = '0;
  int         m_ot = 0, m_t = 0, m_bop = 0, m_bimm = 0, m_bthr = 0;

  logic [7:0] cur_rnd = '0;
  bit         accepted, obs_gr;

  typedef struct { logic [7:0] d; int th; } st_t;
  st_t obs [$];

  function automatic void exec_op(input int op, input int imm, input int th,
                                  input logic [7:0] rd, input logic [7:0] rnd);
    logic [7:0] tmp;
    int k;
    tmp = '0;
    case (op)
      1: m_r2[th] = rd;
      2: m_r1[th] = m_r2[th];
      3: m_r2[th] = m_r1[th] ^ m_r2[th];
      4: begin
        k = imm % DIM;
        for (int i = 0; i < DIM; i++) tmp[(i + k) % DIM] = m_r2[th][i];
        m_r2[th] = tmp;
      end
      5: for (int i = 0; i < DIM; i++) begin
        if (m_r2[th][i]) m_cnt[th][i] = (m_cnt[th][i] + 1 > CMAX) ? CMAX : m_cnt[th][i] + 1;
        else             m_cnt[th][i] = (m_cnt[th][i] - 1 < CMIN) ? CMIN : m_cnt[th][i] - 1;
      end
      6: begin
        for (int i = 0; i < DIM; i++) begin
          if (m_cnt[th][i] > 0)      tmp[i] = 1'b1;
          else if (m_cnt[th][i] < 0) tmp[i] = 1'b0;
          else                       tmp[i] = rnd[i];
          m_cnt[th][i] = 0;
        end
        m_r2[th] = tmp;
      end
      8: m_item[imm] = m_r2[th];
      default: ;
    endcase
  endfunction

  // One clock cycle: drive inputs, compare DUT against model, advance model.
  task automatic cyc(input bit r, input bit iv, input logic [15:0] inst,
                     input bit g, input int ga, input bit ordy);
    bit e_stall, e_inr, e_gr, acc, ex;
    logic [7:0] rd;
    st_t s;
    rst = r; in_valid = iv; in_inst = inst; gen = g;
    gen_addr = 4'(ga); out_ready = ordy; rand_num = cur_rnd;
    #1;
    e_stall = m_ov && !ordy;
    e_inr   = m_run && !e_stall;
    e_gr    = m_run && !(m_bv && m_bop == 8);
    obs_gr  = gen_ready;
    if (m_known) begin
      chk("in_ready", 32'(in_ready), 32'(e_inr));
      chk("gen_ready", 32'(gen_ready), 32'(e_gr));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("last", 32'(last), 32'(m_last));
      if (m_ov) begin
        chk("out_data", 32'(out_data), 32'(m_od));
        chk("out_thread", 32'(out_thread), 32'(m_ot));
      end
    end
    if (out_valid && ordy) begin
      s.d = out_data; s.th = int'(out_thread);
      obs.push_back(s);
    end
    acc = iv && e_inr;
    ex  = m_bv && !e_stall && !r;
    accepted = acc;
    rd = m_item[inst[3:0]];
    if (g && e_gr) m_item[ga] = cur_rnd;
    if (ex) exec_op(m_bop, m_bimm, m_bthr, m_brd, cur_rnd);
    if (r) begin
      m_known = 1; m_run = 0; m_t = 0; m_bv = 0;
      m_ov = 0; m_od = '0; m_ot = 0; m_last = 0;
      for (int th = 0; th < THREADS; th++)
        for (int i = 0; i < DIM; i++) m_cnt[th][i] = 0;
    end else begin
      m_run  = 1;
      m_last = ex && m_bop == 15;
      if (ex && m_bop == 7) begin
        m_ov = 1; m_od = m_r2[m_bthr]; m_ot = m_bthr;
      end else if (ordy) m_ov = 0;
      if (!e_stall) begin
        m_bv = acc;
        if (acc) begin
          m_bop = int'(inst[15:12]); m_bimm = int'(inst[3:0]);
          m_bthr = m_t; m_brd = rd;
        end
      end
      if (acc) m_t = (m_t + 1) % THREADS;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input int op, input int imm);
    int tries = 0;
    accepted = 0;
    while (!accepted && tries < 20) begin
      cyc(0, 1, {4'(op), 8'h00, 4'(imm)}, 0, 0, 1);
      tries++;
    end
    if (!accepted) chk("issue_timeout", 32'(0), 32'(1));
  endtask

  task automatic align0();
    if (m_t != 0) issue(0, 0);
  endtask

  // Thread-0 instruction followed by a thread-1 NOP (keeps rand_num stable
  // through the execute cycle).
  task automatic t0(input int op, input int imm);
    align0();
    issue(op, imm);
    issue(0, 0);
  endtask

  task automatic gen_item(input int a, input logic [7:0] v);
    cur_rnd = v;
    cyc(0, 0, 16'h0, 1, a, 1);
  endtask

  task automatic drain(input int n);
    int tries = 0;
    while (obs.size() < n && tries < 20) begin
      cyc(0, 0, 16'h0, 0, 0, 1);
      tries++;
    end
    if (obs.size() < n) chk("drain_timeout", 32'(obs.size()), 32'(n));
  endtask

  task automatic expect_store(input string nm, input logic [7:0] d, input int th);
    st_t s;
    if (obs.size() == 0) chk({nm, "_missing"}, 32'(0), 32'(1));
    else begin
      s = obs.pop_front();
      chk(nm, 32'(s.d), 32'(d));
      chk({nm, "_thr"}, 32'(s.th), 32'(th));
    end
  endtask

  initial begin
    rst = 1; gen = 0; gen_addr = '0; in_valid = 0; in_inst = '0;
    out_ready = 1; rand_num = '0;
    @(negedge clk);
    cyc(1, 0, 16'h0, 0, 0, 1);
    cyc(1, 1, 16'h1000, 1, 0, 1);
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_gen_ready", 32'(gen_ready), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_out_thread", 32'(out_thread), 32'(0));
    chk("rst_last", 32'(last), 32'(0));
    cyc(0, 0, 16'h0, 0, 0, 1);
    chk("in_ready_after_rst", 32'(in_ready), 32'(1));

    for (int a = 0; a < 16; a++) gen_item(a, 8'($urandom));
    issue(1, 0); issue(1, 1); issue(2, 0); issue(2, 0); issue(1, 2); issue(1, 3);

    // gen then LOAD / STORE
    obs.delete();
    gen_item(3, 8'hA5);
    align0();
    issue(1, 3); issue(0, 0); issue(7, 0); issue(0, 0);
    drain(1);
    expect_store("load_store", 8'hA5, 0);

    // PERM rotate by 1 and by 9 (mod 8)
    obs.delete();
    gen_item(5, 8'h81);
    t0(1, 5); t0(4, 1); t0(7, 0);
    drain(1);
    expect_store("perm1", 8'h03, 0);
    t0(1, 5); t0(4, 9); t0(7, 0);
    drain(1);
    expect_store("perm9", 8'h03, 0);

    // ACC / SIGN with saturation
    obs.delete();
    gen_item(6, 8'hFF); gen_item(7, 8'h0F); gen_item(8, 8'hF0); gen_item(9, 8'h00);
    t0(1, 6);
    repeat (5) t0(5, 0);
    cur_rnd = 8'h00; t0(6, 0); t0(7, 0);
    drain(1);
    expect_store("sign_pos", 8'hFF, 0);
    t0(1, 6);
    repeat (5) t0(5, 0);
    t0(1, 9);
    repeat (3) t0(5, 0);
    cur_rnd = 8'h00; t0(6, 0); t0(7, 0);
    drain(1);
    expect_store("sat_pos", 8'h00, 0);
    t0(1, 7); t0(5, 0); t0(1, 8); t0(5, 0);
    cur_rnd = 8'h5A; t0(6, 0); t0(7, 0);
    drain(1);
    expect_store("sign_tie", 8'h5A, 0);
    t0(1, 9);
    repeat (5) t0(5, 0);
    t0(1, 6);
    repeat (4) t0(5, 0);
    cur_rnd = 8'hFF; t0(6, 0); t0(7, 0);
    drain(1);
    expect_store("sat_neg", 8'hFF, 0);

    // Backpressure on a pending store
    obs.delete();
    align0();
    issue(1, 5); issue(0, 0); issue(7, 0);
    cyc(0, 1, 16'h0000, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("stall_in_ready", 32'(in_ready), 32'(0));
      chk("stall_out_data", 32'(out_data), 32'h81);
      cyc(0, 1, 16'h7000, 0, 0, 0);
    end
    chk("stall_no_handshake", 32'(obs.size()), 32'(0));
    cyc(0, 1, 16'h7000, 0, 0, 1);
    chk("release_one_handshake", 32'(obs.size()), 32'(1));
    chk("release_accepted", 32'(accepted), 32'(1));
    drain(2);
    expect_store("stall_store", 8'h81, 0);
    expect_store("resume_store", 8'h81, 0);

    // WB colliding with gen, plus read-before-write on the LOAD
    obs.delete();
    align0();
    issue(1, 5); issue(0, 0); issue(8, 10);
    cur_rnd = 8'h77;
    cyc(0, 1, 16'h0000, 1, 10, 1);
    chk("wb_gen_collide", 32'(obs_gr), 32'(0));
    cyc(0, 1, 16'h100A, 1, 10, 1);
    chk("gen_after_wb", 32'(obs_gr), 32'(1));
    issue(1, 10); issue(7, 0); issue(7, 0);
    drain(2);
    expect_store("wb_value", 8'h81, 0);
    expect_store("gen_value", 8'h77, 1);

    // Reset with a store pending
    obs.delete();
    align0();
    issue(1, 6); issue(0, 0); issue(5, 0); issue(0, 0); issue(7, 0);
    cyc(0, 0, 16'h0, 0, 0, 0);
    cyc(0, 0, 16'h0, 0, 0, 0);
    cyc(1, 0, 16'h0, 0, 0, 0);
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    cyc(0, 0, 16'h0, 0, 0, 1);
    cur_rnd = 8'h3C;
    issue(6, 0); issue(0, 0); issue(7, 0);
    drain(1);
    chk("midrst_one_store", 32'(obs.size()), 32'(1));
    expect_store("midrst_sign", 8'h3C, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bit r, iv, g, ordy;
      logic [15:0] inst;
      r    = ($urandom_range(0, 299) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      g    = ($urandom_range(0, 2) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      inst = 16'($urandom);
      cur_rnd = 8'($urandom);
      cyc(r, iv, inst, g, int'($urandom_range(0, 15)), ordy);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
